serial_tx: RTL
==============

# serial_tx

Parallel-in, serial-out frame transmitter: the sending end for the team's 8-bit serial-in shift register, which loads at the MSB and shifts right. Accepts one byte per valid/ready handshake and drives it on a single line as an idle-high frame: start bit, 8 data bits LSB first, optional parity bit, stop bit. A receiver built from the shift register in serial-in mode, sampling once per bit period, ends with the byte correctly ordered in bits [7:0].

## Interface
Parameters:
- CLKS_PER_BIT, 16: clock cycles per bit period; legal values ≥ 2.
- PARITY_EN, 0: 1 inserts a parity bit between data and stop.
- PARITY_ODD, 1: with PARITY_EN=1, 1 selects odd parity and 0 selects even parity.

Ports:
- clk  in  1  single clock, all state updates on the rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- tx_valid  in  1  upstream has a byte on tx_data.
- tx_ready  out  1  registered; high only in IDLE.
- tx_data  in  8  byte to send; sampled only on a handshake.
- tx  out  1  registered serial line; idles high.
- busy  out  1  registered; high from the handshake until the frame completes.

## Operation
- Reset (rst_n=0 at an edge): state=IDLE, tx=1, busy=0, tx_ready=0, shift register=0, baud and bit counters=0.
  - tx_ready rises at the first edge with rst_n=1.
- Handshake: tx_valid && tx_ready at an edge. On that edge the block:
  - latches tx_data into the shift register;
  - computes parity as ^tx_data, XORed with PARITY_ODD;
  - moves to START and sets tx=0, busy=1, tx_ready=0.
- While not in IDLE, tx_valid and tx_data are ignored.
- State machine (states IDLE, START, DATA, PARITY, STOP):
  - Each non-IDLE state holds for exactly CLKS_PER_BIT cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1 and clears on every state or bit transition.
  - START→DATA: tx=shreg[0], bit counter=0.
  - In DATA, at each bit-period end the shift register shifts right (zero fill) and tx takes the new shreg[0].
  - After bit 7 completes, DATA goes to PARITY if PARITY_EN=1 (tx=parity), otherwise to STOP (tx=1).
  - PARITY→STOP: tx=1.
  - STOP→IDLE: tx stays 1, busy=0, tx_ready=1.
- Width rules:
  - Baud counter width is $clog2(CLKS_PER_BIT).
  - Bit counter is 3 bits and never wraps past 7 within a frame.
- Reset mid-frame aborts the frame. At the next edge all reset values apply, tx returns high, and no partial state survives.

## Timing
- N = CLKS_PER_BIT, F = 10 + PARITY_EN bit periods.
- Handshake at edge k:
  - tx=0 during cycles k+1 .. k+N.
  - Data bit i is on tx during cycles k+(1+i)N+1 .. k+(2+i)N.
- Stop bit ends at edge k+F·N. busy falls and tx_ready rises on that edge.
- Earliest next handshake is edge k+F·N+1. Back-to-back frame period is F·N+1 cycles, including one idle-high cycle between frames.
- tx never glitches. It changes only on bit-period boundaries or on reset.

## Structure
- Shared package serial_pkg holds:
  - the state encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3 bits);
  - DATA_BITS=8;
  - the line levels IDLE_LEVEL=1, START_LEVEL=0, STOP_LEVEL=1.
  
  The matching receiver reuses this package.
- One sub-module, baud_gen:
  - baud counter with inputs clk, rst_n, clr;
  - output tick, asserted in the last cycle of each bit period.
  
  The FSM, shift register, and parity logic stay in serial_tx.

## Test plan
- Basic frame: N=4, PARITY_EN=0, send 0xA5 → tx reads 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles. busy falls at edge k+40.
- Parity: PARITY_EN=1, PARITY_ODD=1.
  - Send 0x03 → parity bit=1 and frame is 44 cycles.
  - Send 0x07 → parity bit=0.
  - With PARITY_ODD=0, 0x03 → parity bit=0.
- Back-to-back: tx_valid held high with 0x55 then 0xFF → second start bit begins exactly 41 cycles after the first (N=4, no parity). There is a single idle-high cycle between frames, and 0x55 is sent unaltered.
- Data hold: change tx_data from 0x12 to 0xEE mid-frame → the serialised bits remain 0x12 and no second handshake occurs until tx_ready=1.
- Reset mid-frame: rst_n=0 during DATA bit 3 → on the next edge tx=1, busy=0, tx_ready=0. tx_ready=1 one edge after release, and a new frame then transmits correctly.
- Reset values: hold rst_n=0 with tx_valid=1 → tx=1, busy=0, tx_ready=0, and no frame starts.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame transmitter and its matching receiver:
// state encoding, frame geometry, line levels and the parity helper.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int          DATA_BITS   = 8;
    localparam logic [2:0]  LAST_BIT    = 3'(DATA_BITS - 1);

    localparam logic        IDLE_LEVEL  = 1'b1;
    localparam logic        START_LEVEL = 1'b0;
    localparam logic        STOP_LEVEL  = 1'b1;

    // Odd parity makes the total count of ones (data + parity) odd.
    function automatic logic parity_f(input logic [DATA_BITS-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/serial_tx_baud_gen.sv
// Bit-period counter: tick marks the last clock cycle of each bit period;
// clr holds the count at zero so a new period starts aligned to the caller.
module baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_r;
    logic          tick_s;

    assign tick_s = (cnt_r == LAST_CNT);
    assign tick   = tick_s;

    // Counter register: wraps after the last cycle of a period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr || tick_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Frame transmitter: start bit, 8 data bits LSB first, optional parity, stop bit,
// idle-high line, one byte accepted per valid/ready handshake.
module serial_tx
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       busy
);

    localparam logic ODD_SEL = (PARITY_ODD != 0);
    localparam logic PAR_ON  = (PARITY_EN != 0);

    state_t     state_r, state_next_s;
    logic       tx_r, tx_next_s;
    logic       busy_r;
    logic       tx_ready_r;
    logic [7:0] shreg_r, shreg_next_s;
    logic [2:0] bit_cnt_r, bit_cnt_next_s;
    logic       par_r, par_next_s;
    logic       clr_s;
    logic       tick_s;

    baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_s),
        .tick  (tick_s)
    );

    // Next-state and next-line-level logic.
    always_comb begin
        state_next_s   = state_r;
        tx_next_s      = tx_r;
        shreg_next_s   = shreg_r;
        bit_cnt_next_s = bit_cnt_r;
        par_next_s     = par_r;
        clr_s          = 1'b0;
        case (state_r)
            IDLE: begin
                clr_s     = 1'b1;
                tx_next_s = IDLE_LEVEL;
                if (tx_valid && tx_ready_r) begin
                    state_next_s = START;
                    shreg_next_s = tx_data;
                    par_next_s   = parity_f(tx_data, ODD_SEL);
                    tx_next_s    = START_LEVEL;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (tick_s) begin
                    state_next_s   = DATA;
                    tx_next_s      = shreg_r[0];
                    bit_cnt_next_s = 3'd0;
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (tick_s) begin
                    if (bit_cnt_r == LAST_BIT) begin
                        if (PAR_ON) begin
                            state_next_s = PARITY;
                            tx_next_s    = par_r;
                        end else begin
                            state_next_s = STOP;
                            tx_next_s    = STOP_LEVEL;
                        end
                    end else begin
                        // The next bit to send is shreg[1] before this shift lands.
                        shreg_next_s   = {1'b0, shreg_r[7:1]};
                        tx_next_s      = shreg_r[1];
                        bit_cnt_next_s = bit_cnt_r + 3'd1;
                    end
                end else begin
                    state_next_s = DATA;
                end
            end
            PARITY: begin
                if (tick_s) begin
                    state_next_s = STOP;
                    tx_next_s    = STOP_LEVEL;
                end else begin
                    state_next_s = PARITY;
                end
            end
            STOP: begin
                if (tick_s) begin
                    state_next_s = IDLE;
                    tx_next_s    = IDLE_LEVEL;
                end else begin
                    state_next_s = STOP;
                end
            end
            default: begin
                state_next_s = IDLE;
                tx_next_s    = IDLE_LEVEL;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            tx_r       <= IDLE_LEVEL;
            busy_r     <= 1'b0;
            tx_ready_r <= 1'b0;
            shreg_r    <= 8'h00;
            bit_cnt_r  <= 3'd0;
            par_r      <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            tx_r       <= tx_next_s;
            busy_r     <= (state_next_s != IDLE);
            tx_ready_r <= (state_next_s == IDLE);
            shreg_r    <= shreg_next_s;
            bit_cnt_r  <= bit_cnt_next_s;
            par_r      <= par_next_s;
        end
    end

    assign tx       = tx_r;
    assign busy     = busy_r;
    assign tx_ready = tx_ready_r;

endmodule
